// File: rtl/core_defs_pkg.sv
// rtl/core_defs_pkg.sv - shared core constants: widths, reset values, fetch states, opcodes
package core_defs_pkg;

    localparam int          CORE_XLEN      = 32;
    localparam logic [31:0] CORE_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] CORE_NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_FETCH = 2'b01;
    localparam logic [1:0] ST_HOLD  = 2'b10;
    localparam logic [1:0] ST_HALT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        HOLD  = ST_HOLD,
        HALT  = ST_HALT
    } fetch_state_t;

    // Decoder opcode classes, instr[6:2]; instr[1:0] is always 2'b11 for RV32I.
    localparam logic [4:0] OP_LW  = 5'b00000;
    localparam logic [4:0] OP_I   = 5'b00100;
    localparam logic [4:0] OP_S   = 5'b01000;
    localparam logic [4:0] OP_R   = 5'b01100;
    localparam logic [4:0] OP_B   = 5'b11000;
    localparam logic [4:0] OP_JAL = 5'b11011;

    function automatic logic [6:0] opcode7(input logic [4:0] op);
        return {op, 2'b11};
    endfunction

endpackage

// File: rtl/next_pc_gen.sv
// rtl/next_pc_gen.sv - combinational next-PC select with word-alignment check
module next_pc_gen #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm_ext,
    input  logic            PC_src,
    output logic [XLEN-1:0] next,
    output logic            misaligned
);

    // Modulo-2^XLEN add; overflow wraps silently.
    assign next       = pc + (PC_src ? imm_ext : XLEN'(4));
    assign misaligned = |next[1:0];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch stage: PC register, imem req/ack, instruction hold for decode
module fetch_unit
    import core_defs_pkg::*;
#(
    parameter int          XLEN      = CORE_XLEN,
    parameter logic [31:0] RESET_PC  = CORE_RESET_PC,
    parameter int          IMEM_AW   = 10,
    parameter logic [31:0] NOP_INSTR = CORE_NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               PC_src,
    input  logic [XLEN-1:0]    imm_ext,
    input  logic               retire,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               imem_ack,
    output logic [31:0]        instr,
    output logic               instr_valid,
    output logic [XLEN-1:0]    pc_out,
    output logic [XLEN-1:0]    pc_plus4,
    output logic               misalign,
    output logic [31:0]        retired_count
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic            next_misaligned;

    next_pc_gen #(.XLEN(XLEN)) u_next_pc_gen (
        .pc         (pc),
        .imm_ext    (imm_ext),
        .PC_src     (PC_src),
        .next       (next_pc),
        .misaligned (next_misaligned)
    );

    assign imem_addr = pc[IMEM_AW+1:2];
    assign pc_out    = pc;
    assign pc_plus4  = pc + XLEN'(4);

    // imem_req / instr_valid are registered alongside state so they never depend on inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pc            <= XLEN'(RESET_PC);
            instr         <= NOP_INSTR;
            instr_valid   <= 1'b0;
            imem_req      <= 1'b0;
            misalign      <= 1'b0;
            retired_count <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (retire) begin
                        instr_valid <= 1'b0;
                        if (next_misaligned) begin
                            misalign <= 1'b1;
                            state    <= HALT;
                        end else begin
                            pc            <= next_pc;
                            retired_count <= retired_count + 32'd1;
                            imem_req      <= 1'b1;
                            state         <= FETCH;
                        end
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a transaction-level model
module tb_fetch_unit;
    import core_defs_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        PC_src;
    logic [31:0] imm_ext;
    logic        retire;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        misalign;
    logic [31:0] retired_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc, m_cnt, m_instr;
    logic        m_halted;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .PC_src        (PC_src),
        .imm_ext       (imm_ext),
        .retire        (retire),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ack      (imem_ack),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .misalign      (misalign),
        .retired_count (retired_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [31:0] addi_word();
        logic [31:0] w;
        w      = $urandom();
        w[6:0] = opcode7(OP_I);
        return w;
    endfunction

    task automatic check_common();
        check_eq("pc_out", pc_out, m_pc);
        check_eq("retired_count", retired_count, m_cnt);
        check_eq("instr", instr, m_instr);
    endtask

    task automatic check_fetch_phase();
        check_eq("fetch_req", {31'd0, imem_req}, 32'd1);
        check_eq("fetch_addr", {22'd0, imem_addr}, {22'd0, m_pc[11:2]});
        check_eq("fetch_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("fetch_misalign", {31'd0, misalign}, 32'd0);
        check_common();
    endtask

    task automatic check_hold_phase();
        check_eq("hold_req", {31'd0, imem_req}, 32'd0);
        check_eq("hold_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("pc_plus4", pc_plus4, m_pc + 32'd4);
        check_common();
    endtask

    // Entered with the DUT requesting; acks after `waits` idle cycles while retire noise is driven.
    task automatic do_fetch(input int waits, input logic [31:0] word);
        for (int i = 0; i <= waits; i++) begin
            check_fetch_phase();
            retire     = 1'($urandom_range(0, 1));
            PC_src     = 1'($urandom_range(0, 1));
            imm_ext    = $urandom();
            imem_ack   = (i == waits);
            imem_rdata = (i == waits) ? word : $urandom();
            tick();
        end
        imem_ack = 1'b0;
        retire   = 1'b0;
        m_instr  = word;
    endtask

    task automatic do_retire(input int waits, input logic src, input logic [31:0] imm);
        logic [31:0] nxt;
        for (int i = 0; i < waits; i++) begin
            check_hold_phase();
            retire     = 1'b0;
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = $urandom();
            PC_src     = 1'($urandom_range(0, 1));
            imm_ext    = $urandom();
            tick();
        end
        check_hold_phase();
        retire   = 1'b1;
        PC_src   = src;
        imm_ext  = imm;
        imem_ack = 1'b0;
        tick();
        retire = 1'b0;
        nxt = src ? m_pc + imm : m_pc + 32'd4;
        if (nxt % 4 != 0) m_halted = 1'b1;
        else begin
            m_pc  = nxt;
            m_cnt = m_cnt + 32'd1;
        end
    endtask

    task automatic check_halt(input int n);
        for (int i = 0; i < n; i++) begin
            check_eq("halt_req", {31'd0, imem_req}, 32'd0);
            check_eq("halt_valid", {31'd0, instr_valid}, 32'd0);
            check_eq("halt_misalign", {31'd0, misalign}, 32'd1);
            check_common();
            retire     = 1'($urandom_range(0, 1));
            PC_src     = 1'($urandom_range(0, 1));
            imm_ext    = $urandom() & 32'hFFFF_FFFC;
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = $urandom();
            tick();
        end
        retire   = 1'b0;
        imem_ack = 1'b0;
    endtask

    task automatic model_reset();
        m_pc     = CORE_RESET_PC;
        m_cnt    = 32'd0;
        m_instr  = CORE_NOP_INSTR;
        m_halted = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        check_eq({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        check_eq({tag, "_misalign"}, {31'd0, misalign}, 32'd0);
        check_eq({tag, "_instr"}, instr, CORE_NOP_INSTR);
        check_eq({tag, "_pc"}, pc_out, CORE_RESET_PC);
        check_eq({tag, "_cnt"}, retired_count, 32'd0);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        imem_ack   = 1'($urandom_range(0, 1));
        imem_rdata = $urandom();
        retire     = 1'($urandom_range(0, 1));
        tick();
        tick();
        rst      = 1'b0;
        imem_ack = 1'b0;
        retire   = 1'b0;
        model_reset();
        check_reset_state("reset");
        tick();
    endtask

    initial begin
        rst        = 1'b1;
        PC_src     = 1'b0;
        imm_ext    = 32'd0;
        retire     = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        model_reset();
        tick();
        do_reset();

        // sequential fetch, zero wait
        for (int k = 0; k < 3; k++) begin
            do_fetch(0, addi_word());
            do_retire(0, 1'b0, 32'd0);
        end
        check_eq("seq_cnt3", retired_count, 32'd3);
        check_eq("seq_pc", pc_out, 32'h0000_000C);

        // taken backward branch from 0x10
        do_fetch(0, addi_word());
        do_retire(0, 1'b0, 32'd0);
        check_eq("pre_branch_pc", pc_out, 32'h0000_0010);
        do_fetch(0, addi_word());
        do_retire(0, 1'b1, 32'hFFFF_FFF8);
        check_eq("branch_addr", {22'd0, imem_addr}, 32'd2);
        check_eq("branch_pc", pc_out, 32'h0000_0008);

        // JAL from 0x20
        do_fetch(0, addi_word());
        do_retire(0, 1'b1, 32'h0000_0018);
        do_fetch(0, {12'h000, 5'd0, 3'd0, 5'd1, opcode7(OP_JAL)});
        check_eq("jal_pc_plus4", pc_plus4, 32'h0000_0024);
        do_retire(0, 1'b1, 32'h0000_0100);
        check_eq("jal_target", pc_out, 32'h0000_0120);

        // three wait states
        do_fetch(3, addi_word());
        do_retire(1, 1'b0, 32'd0);

        for (int k = 0; k < 40; k++) begin
            logic        src;
            src = 1'($urandom_range(0, 1));
            do_fetch(int'($urandom_range(0, 3)), addi_word());
            do_retire(int'($urandom_range(0, 2)), src, $urandom() & 32'hFFFF_FFFC);
        end

        // wrap past top of address space
        do_fetch(0, addi_word());
        do_retire(0, 1'b1, 32'hFFFF_FFFC - m_pc);
        check_eq("wrap_top_pc", pc_out, 32'hFFFF_FFFC);
        do_fetch(1, addi_word());
        do_retire(0, 1'b0, 32'd0);
        check_eq("wrap_pc", pc_out, 32'h0000_0000);

        // reset mid-fetch with coincident ack
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = addi_word();
        tick();
        rst      = 1'b0;
        imem_ack = 1'b0;
        model_reset();
        check_reset_state("midfetch");
        tick();

        // misaligned target at 0x40
        do_fetch(0, addi_word());
        do_retire(0, 1'b1, 32'h0000_0040);
        do_fetch(2, addi_word());
        do_retire(0, 1'b1, 32'h0000_0006);
        check_eq("misalign_model", {31'd0, m_halted}, 32'd1);
        check_eq("misalign_flag", {31'd0, misalign}, 32'd1);
        check_eq("misalign_pc", pc_out, 32'h0000_0040);
        check_halt(6);
        do_reset();
        do_fetch(0, addi_word());
        do_retire(0, 1'b0, 32'd0);
        check_eq("post_halt_pc", pc_out, 32'h0000_0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
